// File: rtl/id_ex_operand_stage_if.sv
// ID/EX stage bundle: decode inputs, bypass sources and registered EX-stage outputs.
// The upstream pipeline drives the master side; the ID/EX stage is the slave.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
);
  logic              IdValid;
  logic [REG_W-1:0]  IdRA;
  logic [REG_W-1:0]  IdRB;
  logic [REG_W-1:0]  IdRW;
  logic              IdRegWr;
  logic              IdMemRd;
  logic [DATA_W-1:0] IdImm;
  logic [15:0]       IdCtrl;
  logic [DATA_W-1:0] BusA;
  logic [DATA_W-1:0] BusB;
  logic              ExMemRegWr;
  logic [REG_W-1:0]  ExMemRW;
  logic [DATA_W-1:0] ExMemResult;
  logic              MemWbRegWr;
  logic [REG_W-1:0]  MemWbRW;
  logic [DATA_W-1:0] MemWbResult;
  logic              Flush;
  logic              StallOut;
  logic              ExValid;
  logic              ExRegWr;
  logic              ExMemRd;
  logic [DATA_W-1:0] ExA;
  logic [DATA_W-1:0] ExB;
  logic [DATA_W-1:0] ExImm;
  logic [REG_W-1:0]  ExRA;
  logic [REG_W-1:0]  ExRB;
  logic [REG_W-1:0]  ExRW;
  logic [15:0]       ExCtrl;
  logic [15:0]       StallCnt;

  modport master (
    output IdValid, IdRA, IdRB, IdRW, IdRegWr, IdMemRd, IdImm, IdCtrl, BusA, BusB,
           ExMemRegWr, ExMemRW, ExMemResult, MemWbRegWr, MemWbRW, MemWbResult, Flush,
    input  StallOut, ExValid, ExRegWr, ExMemRd, ExA, ExB, ExImm, ExRA, ExRB, ExRW,
           ExCtrl, StallCnt
  );

  modport slave (
    input  IdValid, IdRA, IdRB, IdRW, IdRegWr, IdMemRd, IdImm, IdCtrl, BusA, BusB,
           ExMemRegWr, ExMemRW, ExMemResult, MemWbRegWr, MemWbRW, MemWbResult, Flush,
    output StallOut, ExValid, ExRegWr, ExMemRd, ExA, ExB, ExImm, ExRA, ExRB, ExRW,
           ExCtrl, StallCnt
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand bypass, load-use bubble
// insertion, branch flush and a saturating bubble counter.
module id_ex_operand_stage #(
  parameter int DATA_W   = 64,
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input logic               Clk,
  input logic               Reset,
  id_ex_operand_stage_if.slave bus
);
  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  logic              ex_valid_q, ex_valid_d;
  logic              ex_reg_wr_q, ex_reg_wr_d;
  logic              ex_mem_rd_q, ex_mem_rd_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [REG_W-1:0]  ex_ra_q, ex_ra_d;
  logic [REG_W-1:0]  ex_rb_q, ex_rb_d;
  logic [REG_W-1:0]  ex_rw_q, ex_rw_d;
  logic [15:0]       ex_ctrl_q, ex_ctrl_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic              hz;
  logic [DATA_W-1:0] op_a, op_b;

  // EX/MEM is the younger producer, so it must win over MEM/WB.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_W-1:0]  idx,
    input logic [DATA_W-1:0] rf_val,
    input logic              em_wr,
    input logic [REG_W-1:0]  em_rw,
    input logic [DATA_W-1:0] em_res,
    input logic              mw_wr,
    input logic [REG_W-1:0]  mw_rw,
    input logic [DATA_W-1:0] mw_res
  );
    if (idx == ZR)                    return '0;
    else if (em_wr && em_rw == idx)   return em_res;
    else if (mw_wr && mw_rw == idx)   return mw_res;
    else                              return rf_val;
  endfunction

  always_comb begin
    hz = bus.IdValid & ex_valid_q & ex_mem_rd_q & ex_reg_wr_q & (ex_rw_q != ZR) &
         ((bus.IdRA == ex_rw_q) | (bus.IdRB == ex_rw_q));
    op_a = fwd(bus.IdRA, bus.BusA, bus.ExMemRegWr, bus.ExMemRW, bus.ExMemResult,
               bus.MemWbRegWr, bus.MemWbRW, bus.MemWbResult);
    op_b = fwd(bus.IdRB, bus.BusB, bus.ExMemRegWr, bus.ExMemRW, bus.ExMemResult,
               bus.MemWbRegWr, bus.MemWbRW, bus.MemWbResult);

    ex_valid_d  = 1'b0;
    ex_reg_wr_d = 1'b0;
    ex_mem_rd_d = 1'b0;
    ex_a_d      = '0;
    ex_b_d      = '0;
    ex_imm_d    = '0;
    ex_ra_d     = '0;
    ex_rb_d     = '0;
    ex_rw_d     = '0;
    ex_ctrl_d   = '0;
    if (!(bus.Flush || hz) && bus.IdValid) begin
      ex_valid_d  = 1'b1;
      ex_reg_wr_d = bus.IdRegWr & (bus.IdRW != ZR);
      ex_mem_rd_d = bus.IdMemRd;
      ex_a_d      = op_a;
      ex_b_d      = op_b;
      ex_imm_d    = bus.IdImm;
      ex_ra_d     = bus.IdRA;
      ex_rb_d     = bus.IdRB;
      ex_rw_d     = bus.IdRW;
      ex_ctrl_d   = bus.IdCtrl;
    end

    stall_cnt_d = stall_cnt_q;
    if (hz && !bus.Flush && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ex_valid_q  <= 1'b0;
      ex_reg_wr_q <= 1'b0;
      ex_mem_rd_q <= 1'b0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_imm_q    <= '0;
      ex_ra_q     <= '0;
      ex_rb_q     <= '0;
      ex_rw_q     <= '0;
      ex_ctrl_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_reg_wr_q <= ex_reg_wr_d;
      ex_mem_rd_q <= ex_mem_rd_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_imm_q    <= ex_imm_d;
      ex_ra_q     <= ex_ra_d;
      ex_rb_q     <= ex_rb_d;
      ex_rw_q     <= ex_rw_d;
      ex_ctrl_q   <= ex_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.StallOut = hz & ~bus.Flush;
  assign bus.ExValid  = ex_valid_q;
  assign bus.ExRegWr  = ex_reg_wr_q;
  assign bus.ExMemRd  = ex_mem_rd_q;
  assign bus.ExA      = ex_a_q;
  assign bus.ExB      = ex_b_q;
  assign bus.ExImm    = ex_imm_q;
  assign bus.ExRA     = ex_ra_q;
  assign bus.ExRB     = ex_rb_q;
  assign bus.ExRW     = ex_rw_q;
  assign bus.ExCtrl   = ex_ctrl_q;
  assign bus.StallCnt = stall_cnt_q;
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Decode-to-execute pipeline register of the 64-bit pipelined CPU, sitting directly downstream of the register file. It captures the two register-file read buses together with decode control and applies EX/MEM and MEM/WB operand bypassing. It detects load-use hazards and inserts bubbles into EX, and it handles branch flushes. Its outputs are the registered EX-stage operands and control.

## Interface

Parameters:
- DATA_W, 64, operand/result width
- REG_W, 5, register index width
- ZERO_REG, 31, hard-wired zero register index

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- IdValid  in  1  decode holds a real instruction
- IdRA, IdRB, IdRW  in  REG_W  source A, source B, destination indexes
- IdRegWr  in  1  instruction writes IdRW
- IdMemRd  in  1  instruction is a load
- IdImm  in  DATA_W  decoded immediate
- IdCtrl  in  16  opaque EX/MEM/WB control bits, passed through
- BusA, BusB  in  DATA_W  register-file read data for IdRA/IdRB (ZERO_REG already reads 0)
- ExMemRegWr, ExMemRW, ExMemResult  in  1/REG_W/DATA_W  producer one stage ahead of EX
- MemWbRegWr, MemWbRW, MemWbResult  in  1/REG_W/DATA_W  producer being written back this cycle
- Flush  in  1  taken branch; kill instruction in ID
- StallOut  out  1  hold PC and IF/ID this cycle (combinational)
- ExValid, ExRegWr, ExMemRd  out  1  registered valid/control
- ExA, ExB, ExImm  out  DATA_W  registered operands
- ExRA, ExRB, ExRW  out  REG_W  registered indexes
- ExCtrl  out  16  registered control
- StallCnt  out  16  saturating count of inserted load-use bubbles

## Operation

- Hazard: Hz = IdValid & ExValid & ExMemRd & ExRegWr & (ExRW != ZERO_REG) & ((IdRA == ExRW) | (IdRB == ExRW)).
- StallOut = Hz & ~Flush.
- Operand select for A (B identical using IdRB/BusB):
  - IdRA == ZERO_REG: 0.
  - Else if ExMemRegWr & ExMemRW == IdRA: ExMemResult.
  - Else if MemWbRegWr & MemWbRW == IdRA: MemWbResult.
  - Else: BusA.
  - EX/MEM takes priority over MEM/WB.
- Each rising edge, in priority order:
  - Flush, or Hz: load a bubble. ExValid, ExRegWr and ExMemRd go 0. ExA, ExB, ExImm, ExCtrl, ExRA, ExRB and ExRW are cleared to 0. On Hz, the ID instruction stays in ID because the upstream holds on StallOut.
  - Else if IdValid: load all Ex* fields from the Id* inputs and the selected operands. ExRegWr is forced 0 when IdRW == ZERO_REG.
  - Else: load a bubble, as for Flush.
- StallCnt increments by 1 on each edge where Hz & ~Flush is true, and saturates at 16'hFFFF.
- Flush and Hz in the same cycle: flush wins. StallOut = 0, one bubble is loaded, StallCnt does not increment.
- Reset (asynchronous, at any time including mid-stall): every output register goes to 0 immediately. StallOut then evaluates to 0 because ExValid = 0.

## Timing

- Latency: ID inputs appear on Ex* outputs one rising edge later.
- StallOut and the forwarding muxes are combinational on the current cycle's inputs and Ex* registers. StallOut must be stable before the rising edge.
- A load-use pair costs exactly one bubble:
  - Cycle n: Hz = 1, bubble loaded.
  - Cycle n+1: ExValid = 0, so Hz = 0 and the consumer enters EX.
  - The consumer's operand then comes from the EX/MEM bypass at the following edge. It does not come from EX.
- MEM/WB bypassing covers the result written back in the same cycle, independent of the register-file write edge. Its value equals the register contents.
- No back-pressure input; EX always accepts.

## Test plan

- Reset: assert Reset mid-cycle with ExValid = 1 and StallCnt = 5 -> all Ex* outputs, StallCnt and StallOut are 0 immediately, before any clock edge.
- Plain pass: IdRA = 1, BusA = 64'h1111, IdRB = 2, BusB = 64'h2222, no bypass sources -> next edge ExA = 64'h1111, ExB = 64'h2222, ExValid = 1.
- Bypass priority: IdRA = 3. ExMemRW = 3 with ExMemResult = 64'hAA, MemWbRW = 3 with MemWbResult = 64'hBB, BusA = 64'hCC -> ExA = 64'hAA. Drop ExMemRegWr -> ExA = 64'hBB. Set IdRA = 31 with both sources naming 31 -> ExA = 0.
- Load-use: load writing X5 in EX (ExMemRd = 1), then IdRA = 5 -> StallOut = 1 for exactly one cycle, one bubble (ExValid = 0), StallCnt = 1. Next edge the consumer enters EX with StallOut = 0.
- Flush vs stall: same load-use setup with Flush = 1 -> StallOut = 0, bubble loaded, StallCnt unchanged.
- Saturation: preload 65534 hazards, then 3 more -> StallCnt holds at 16'hFFFF.
